// File: rtl/ask_uart_pkg.sv
// Shared definitions for the ASK UART blocks.
//   uart_state_e   : receive FSM state encoding (IDLE/START/DATA/STOP)
//   DATA_BITS      : data bits per UART frame
//   STOP_BITS      : stop bits per UART frame
//   ask_sum_width  : width of the windowed magnitude sum that cannot overflow
package ask_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // WIN samples of ASK_WIDTH bits each sum to at most WIN*(2^ASK_WIDTH-1).
  function automatic int unsigned ask_sum_width(input int unsigned ask_width,
                                                input int unsigned win);
    return ask_width + $clog2(win + 1);
  endfunction

endpackage

// File: rtl/ask_window_integrator.sv
// Sliding-window integrator for ASK magnitude samples.
// Keeps the last WIN samples in a delay line and maintains their sum
// incrementally (sum + newest - oldest). Output is registered (1 clk).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   sample    : unsigned ASK magnitude sample, one per clk
//   sum       : sum of the last WIN samples, SW bits
module ask_window_integrator
  import ask_uart_pkg::*;
#(
  parameter int unsigned ASK_WIDTH = 8,
  parameter int unsigned WIN       = 13,
  parameter int unsigned SW        = ask_sum_width(ASK_WIDTH, WIN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ASK_WIDTH-1:0] sample,
  output logic [SW-1:0]        sum
);

  logic [ASK_WIDTH-1:0] dly_q [WIN];
  logic [ASK_WIDTH-1:0] dly_d [WIN];
  logic [SW-1:0]        sum_q;
  logic [SW-1:0]        sum_d;

  always_comb begin
    dly_d[0] = sample;
    for (int unsigned i = 1; i < WIN; i++) begin
      dly_d[i] = dly_q[i-1];
    end
    // sum_q + sample never exceeds (WIN+1)*max, which still fits in SW bits.
    sum_d = sum_q + SW'(sample) - SW'(dly_q[WIN-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIN; i++) begin
        dly_q[i] <= '0;
      end
      sum_q <= '0;
    end else begin
      for (int unsigned i = 0; i < WIN; i++) begin
        dly_q[i] <= dly_d[i];
      end
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/axis_ask_uart_rx_demod.sv
// ASK UART receiver with AXI-Stream byte output.
// Integrates ASK magnitude samples over a sliding window, slices the sum with
// hysteresis into a line bit, deserialises 8N1 LSB-first and queues bytes in a
// first-word-fall-through FIFO of 2^RX_SIZE entries.
// Optional build macro: ASK_RX_MAJORITY_EN -- 2-of-3 majority vote of the line
// around each bit sample point instead of a single sample.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   ask_rx                        : unsigned ASK sample, one per clk
//   up_threshold/down_threshold   : slicer hysteresis thresholds (SW bits)
//   o_tdata/o_tvalid/o_tready     : AXI-Stream byte output
//   frame_err                     : 1-clk pulse, stop bit sampled as space
//   overflow                      : 1-clk pulse, byte dropped on full FIFO
module axis_ask_uart_rx_demod
  import ask_uart_pkg::*;
#(
  parameter int unsigned ASK_WIDTH = 8,
  parameter int unsigned CLKDIV    = 32,
  parameter int unsigned WIN       = CLKDIV / 2 - 3,
  parameter int unsigned RX_SIZE   = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [ASK_WIDTH-1:0]                    ask_rx,
  input  logic [ask_sum_width(ASK_WIDTH, WIN)-1:0] up_threshold,
  input  logic [ask_sum_width(ASK_WIDTH, WIN)-1:0] down_threshold,
  output logic [7:0]                              o_tdata,
  output logic                                    o_tvalid,
  input  logic                                    o_tready,
  output logic                                    frame_err,
  output logic                                    overflow
);

  localparam int unsigned SW    = ask_sum_width(ASK_WIDTH, WIN);
  localparam int unsigned CW    = $clog2(CLKDIV);
  localparam int unsigned DEPTH = 1 << RX_SIZE;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKDIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKDIV - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  // ---------------------------------------------------------------- integrator
  logic [SW-1:0] sum;

  ask_window_integrator #(
    .ASK_WIDTH (ASK_WIDTH),
    .WIN       (WIN),
    .SW        (SW)
  ) u_integrator (
    .clk    (clk),
    .rst    (rst),
    .sample (ask_rx),
    .sum    (sum)
  );

  // ------------------------------------------------------------------- slicer
  logic line_q, line_d;
  logic line_prev_q, line_prev_d;

  always_comb begin
    line_d = line_q;
    // Checking up first makes it win when the thresholds are ill-ordered.
    if (sum >= up_threshold) begin
      line_d = 1'b1;
    end else if (sum <= down_threshold) begin
      line_d = 1'b0;
    end
    line_prev_d = line_q;
  end

  // ---------------------------------------------------------------- bit value
  logic bit_val;

`ifdef ASK_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  // The vote at the decision cycle uses the two previous line values and the
  // current one, i.e. one clock either side of the cycle before the decision.
  always_comb begin
    hist_d  = {hist_q[0], line_q};
    bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & line_q) | (hist_q[0] & line_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  always_comb begin
    bit_val = line_q;
  end
`endif

  // --------------------------------------------------------------- UART FSM
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_req;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Edge-triggered start: a line held at space after a break cannot
        // retrigger until it has returned to mark.
        if (line_prev_q && !line_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = bit_val;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == STOP && cnt_q == FULL_M1) begin
      push_req    = bit_val;
      frame_err_d = !bit_val;
    end
  end

  // --------------------------------------------------------------------- FIFO
  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [RX_SIZE:0] wr_ptr_q, wr_ptr_d;
  logic [RX_SIZE:0] rd_ptr_q, rd_ptr_d;
  logic             empty, full, push, pop;
  logic             overflow_q, overflow_d;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[RX_SIZE] != rd_ptr_q[RX_SIZE]) &&
            (wr_ptr_q[RX_SIZE-1:0] == rd_ptr_q[RX_SIZE-1:0]);
    pop   = !empty && o_tready;
    // A pop in the same cycle frees the slot, so a push on full is accepted.
    push       = push_req && (!full || pop);
    overflow_d = push_req && full && !pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[RX_SIZE-1:0]] = shift_q;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q      <= 1'b1;
      line_prev_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      line_q      <= line_d;
      line_prev_q <= line_prev_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_tdata   = mem_q[rd_ptr_q[RX_SIZE-1:0]];
  assign o_tvalid  = !empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_axis_ask_uart_rx_demod.sv
module tb_axis_ask_uart_rx_demod;

  localparam int unsigned ASK_WIDTH = 8;
  localparam int unsigned CLKDIV    = 32;
  localparam int unsigned WIN       = 13;
  localparam int unsigned RX_SIZE   = 2;
  localparam int unsigned SW        = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [ASK_WIDTH-1:0] ask_rx = 8'd100;
  logic [SW-1:0]        up_threshold = 12'd501;
  logic [SW-1:0]        down_threshold = 12'd139;
  logic [7:0]           o_tdata;
  logic                 o_tvalid;
  logic                 o_tready = 1'b1;
  logic                 frame_err;
  logic                 overflow;

  int checks   = 0;
  int failures = 0;

  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         tv_cycles = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  axis_ask_uart_rx_demod #(
    .ASK_WIDTH (ASK_WIDTH),
    .CLKDIV    (CLKDIV),
    .WIN       (WIN),
    .RX_SIZE   (RX_SIZE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ask_rx         (ask_rx),
    .up_threshold   (up_threshold),
    .down_threshold (down_threshold),
    .o_tdata        (o_tdata),
    .o_tvalid       (o_tvalid),
    .o_tready       (o_tready),
    .frame_err      (frame_err),
    .overflow       (overflow)
  );

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overflow) ov_cnt++;
    if (o_tvalid) tv_cycles++;
    if (o_tvalid && o_tready) rx_q.push_back(o_tdata);
  end

  task automatic tick_drive(input logic [7:0] v);
    @(posedge clk);
    #1;
    ask_rx = v;
  endtask

  task automatic idle(input int n);
    repeat (n) tick_drive(8'd100);
  endtask

  task automatic send_bit(input logic b);
    repeat (CLKDIV) tick_drive(b ? 8'd100 : 8'd0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ask_rx = 8'd100;
    o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (o_tvalid !== 1'b0) begin
      failures++; $display("FAIL reset_tvalid: got %b expected 0", o_tvalid);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle;
    int tv0, fe0, ov0;
    tv0 = tv_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
    idle(500);
    checks++;
    if (tv_cycles - tv0 !== 0) begin
      failures++; $display("FAIL idle_tvalid: got %0d valid cycles expected 0", tv_cycles - tv0);
    end
    checks++;
    if (fe_cnt - fe0 !== 0) begin
      failures++; $display("FAIL idle_frame_err: got %0d expected 0", fe_cnt - fe0);
    end
    checks++;
    if (ov_cnt - ov0 !== 0) begin
      failures++; $display("FAIL idle_overflow: got %0d expected 0", ov_cnt - ov0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [4];
    int n0, fe0;
    exp_b = '{8'h55, 8'h00, 8'hFF, 8'hA5};
    n0 = rx_q.size(); fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1);
    idle(40);
    checks++;
    if (rx_q.size() - n0 !== 4) begin
      failures++; $display("FAIL b2b_count: got %0d beats expected 4", rx_q.size() - n0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q.size() <= n0 + i) begin
        failures++; $display("FAIL b2b_data%0d: got no beat expected %h", i, exp_b[i]);
      end else if (rx_q[n0+i] !== exp_b[i]) begin
        failures++; $display("FAIL b2b_data%0d: got %h expected %h", i, rx_q[n0+i], exp_b[i]);
      end
    end
    checks++;
    if (fe_cnt - fe0 !== 0) begin
      failures++; $display("FAIL b2b_frame_err: got %0d expected 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_dropout;
    int n0, fe0;
    n0 = rx_q.size(); fe0 = fe_cnt;
    idle(50);
    repeat (8) tick_drive(8'd0);
    idle(400);
    checks++;
    if (rx_q.size() - n0 !== 0) begin
      failures++; $display("FAIL dropout_beats: got %0d expected 0", rx_q.size() - n0);
    end
    checks++;
    if (fe_cnt - fe0 !== 0) begin
      failures++; $display("FAIL dropout_frame_err: got %0d expected 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_frame_err;
    int n0, fe0, tv0;
    n0 = rx_q.size(); fe0 = fe_cnt; tv0 = tv_cycles;
    send_frame(8'h77, 1'b0);
    idle(60);
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      failures++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0);
    end
    checks++;
    if (tv_cycles - tv0 !== 0) begin
      failures++; $display("FAIL ferr_tvalid: got %0d valid cycles expected 0", tv_cycles - tv0);
    end
    send_frame(8'h18, 1'b1);
    idle(40);
    checks++;
    if (rx_q.size() - n0 !== 1) begin
      failures++; $display("FAIL ferr_next_count: got %0d beats expected 1", rx_q.size() - n0);
    end else if (rx_q[n0] !== 8'h18) begin
      failures++; $display("FAIL ferr_next_data: got %h expected 18", rx_q[n0]);
    end
    checks++;
    if (fe_cnt - fe0 !== 1) begin
      failures++; $display("FAIL ferr_total: got %0d expected 1", fe_cnt - fe0);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] exp_b [5];
    int n0, ov0;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    @(posedge clk); #1;
    o_tready = 1'b0;
    n0 = rx_q.size(); ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) send_frame(exp_b[i], 1'b1);
    idle(40);
    checks++;
    if (ov_cnt - ov0 !== 1) begin
      failures++; $display("FAIL ovf_pulses: got %0d expected 1", ov_cnt - ov0);
    end
    checks++;
    if (o_tvalid !== 1'b1) begin
      failures++; $display("FAIL ovf_held_tvalid: got %b expected 1", o_tvalid);
    end
    checks++;
    if (o_tdata !== 8'h11) begin
      failures++; $display("FAIL ovf_head_data: got %h expected 11", o_tdata);
    end
    o_tready = 1'b1;
    idle(20);
    checks++;
    if (rx_q.size() - n0 !== 4) begin
      failures++; $display("FAIL ovf_drain_count: got %0d beats expected 4", rx_q.size() - n0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q.size() <= n0 + i) begin
        failures++; $display("FAIL ovf_drain%0d: got no beat expected %h", i, exp_b[i]);
      end else if (rx_q[n0+i] !== exp_b[i]) begin
        failures++; $display("FAIL ovf_drain%0d: got %h expected %h", i, rx_q[n0+i], exp_b[i]);
      end
    end
    checks++;
    if (o_tvalid !== 1'b0) begin
      failures++; $display("FAIL ovf_empty_tvalid: got %b expected 0", o_tvalid);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int n0, fe0;
    d = 8'h5A;
    @(posedge clk); #1;
    o_tready = 1'b0;
    send_frame(8'h3C, 1'b1);
    idle(40);
    checks++;
    if (o_tvalid !== 1'b1 || o_tdata !== 8'h3C) begin
      failures++; $display("FAIL rstmid_preload: got valid=%b data=%h expected valid=1 data=3c", o_tvalid, o_tdata);
    end
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    repeat (CLKDIV / 2) tick_drive(d[4] ? 8'd100 : 8'd0);
    rst = 1'b1;
    #1;
    checks++;
    if (o_tvalid !== 1'b0) begin
      failures++; $display("FAIL rstmid_tvalid: got %b expected 0", o_tvalid);
    end
    repeat (4) tick_drive(8'd100);
    rst = 1'b0;
    o_tready = 1'b1;
    n0 = rx_q.size(); fe0 = fe_cnt;
    idle(100);
    checks++;
    if (rx_q.size() - n0 !== 0) begin
      failures++; $display("FAIL rstmid_no_partial: got %0d beats expected 0", rx_q.size() - n0);
    end
    send_frame(8'hCA, 1'b1);
    idle(40);
    checks++;
    if (rx_q.size() - n0 !== 1) begin
      failures++; $display("FAIL rstmid_next_count: got %0d beats expected 1", rx_q.size() - n0);
    end else if (rx_q[n0] !== 8'hCA) begin
      failures++; $display("FAIL rstmid_next_data: got %h expected ca", rx_q[n0]);
    end
    checks++;
    if (fe_cnt - fe0 !== 0) begin
      failures++; $display("FAIL rstmid_frame_err: got %0d expected 0", fe_cnt - fe0);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_back_to_back();
    test_dropout();
    test_frame_err();
    test_overflow();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
